// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the direct-mapped write-back data cache.
package cache_pkg;

  localparam int unsigned DEF_ADDR_W     = 11;
  localparam int unsigned DEF_LINES      = 16;
  localparam int unsigned DEF_LINE_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVICT = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic [31:0] addr_off(input logic [31:0] a, input int unsigned off_w);
    return a & ((32'd1 << off_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_idx(input logic [31:0] a, input int unsigned off_w,
                                           input int unsigned idx_w);
    return (a >> off_w) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int unsigned off_w,
                                           input int unsigned idx_w);
    return a >> (off_w + idx_w);
  endfunction

endpackage

// File: rtl/dcache_store.sv
// Cache storage: data/tag arrays (not reset) plus valid/dirty bits; async read, sync write.
module dcache_store
  import cache_pkg::*;
#(
  parameter int unsigned LINES      = DEF_LINES,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
  parameter int unsigned TAG_W      = 5,
  localparam int unsigned IDX_W     = $clog2(LINES),
  localparam int unsigned OFF_W     = $clog2(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [OFF_W-1:0] rd_off_i,
  output logic [31:0]      rd_data_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             valid_o,
  output logic             dirty_o,
  input  logic             wr_en_i,
  input  logic [OFF_W-1:0] wr_off_i,
  input  logic [31:0]      wr_data_i,
  input  logic             fill_done_i,
  input  logic [TAG_W-1:0] fill_tag_i,
  input  logic             dirty_set_i
);

  logic [31:0]      data_q [LINES*LINE_WORDS];
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;

  assign rd_data_o = data_q[{idx_i, rd_off_i}];
  assign tag_o     = tag_q[idx_i];
  assign valid_o   = valid_q[idx_i];
  assign dirty_o   = dirty_q[idx_i];

  always_ff @(posedge clk) begin
    if (wr_en_i) data_q[{idx_i, wr_off_i}] <= wr_data_i;
    if (fill_done_i) tag_q[idx_i] <= fill_tag_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_done_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (dirty_set_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache: miss FSM, hit/miss counters and
// word-per-beat backing-memory handshake.
module dcache_wb
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned LINES      = DEF_LINES,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              we,
  input  logic              re,
  output logic [31:0]       rdata,
  output logic              miss,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  state_e           state_q, state_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  logic [31:0]      addr_ext;
  logic [TAG_W-1:0] a_tag;
  logic [IDX_W-1:0] a_idx;
  logic [OFF_W-1:0] a_off;

  logic [31:0]      st_rd_data, st_wr_data;
  logic [TAG_W-1:0] st_tag;
  logic             st_valid, st_dirty, st_wr_en, st_fill_done, st_dirty_set;
  logic [OFF_W-1:0] st_rd_off, st_wr_off;
  logic             req, hit;

  assign addr_ext = 32'(addr);
  assign a_tag    = TAG_W'(addr_tag(addr_ext, OFF_W, IDX_W));
  assign a_idx    = IDX_W'(addr_idx(addr_ext, OFF_W, IDX_W));
  assign a_off    = OFF_W'(addr_off(addr_ext, OFF_W));

  assign req = re | we;
  assign hit = req & st_valid & (st_tag == a_tag);

  dcache_store #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS),
    .TAG_W      (TAG_W)
  ) u_store (
    .clk         (clk),
    .rst_n       (rst_n),
    .idx_i       (a_idx),
    .rd_off_i    (st_rd_off),
    .rd_data_o   (st_rd_data),
    .tag_o       (st_tag),
    .valid_o     (st_valid),
    .dirty_o     (st_dirty),
    .wr_en_i     (st_wr_en),
    .wr_off_i    (st_wr_off),
    .wr_data_i   (st_wr_data),
    .fill_done_i (st_fill_done),
    .fill_tag_i  (a_tag),
    .dirty_set_i (st_dirty_set)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    miss         = 1'b1;
    rdata        = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    st_rd_off    = a_off;
    st_wr_off    = a_off;
    st_wr_data   = wdata;
    st_wr_en     = 1'b0;
    st_fill_done = 1'b0;
    st_dirty_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        miss = 1'b0;
        if (hit) begin
          hit_cnt_d = hit_cnt_q + 32'd1;
          if (we) begin
            st_wr_en     = 1'b1;
            st_dirty_set = 1'b1;
          end else begin
            rdata = st_rd_data;
          end
        end else if (req) begin
          miss       = 1'b1;
          miss_cnt_d = miss_cnt_q + 32'd1;
          cnt_d      = '0;
          state_d    = (st_valid && st_dirty) ? EVICT : FILL;
        end
      end
      // The read port is borrowed by the beat counter so the victim line streams out.
      EVICT: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        st_rd_off = cnt_q;
        mem_addr  = {st_tag, a_idx, cnt_q};
        mem_wdata = st_rd_data;
        if (mem_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = FILL;
        end
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = {a_tag, a_idx, cnt_q};
        if (mem_ready) begin
          st_wr_en   = 1'b1;
          st_wr_off  = cnt_q;
          st_wr_data = mem_rdata;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            st_fill_done = 1'b1;
            state_d      = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_dcache_wb.sv
// Scoreboard bench for dcache_wb: a flat architectural memory model predicts load data,
// a tag-only line model predicts hit/miss and stall lengths.
module tb_dcache_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] addr;
  logic [31:0] wdata;
  logic        we, re;
  logic [31:0] rdata;
  logic        miss;
  logic        mem_req, mem_we;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ready;
  logic [31:0] hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  dcache_wb #(.ADDR_W(11), .LINES(16), .LINE_WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .miss(miss), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic finish_sim();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  endtask

  // Backing memory (responder side) and architectural view (what loads must return).
  logic [31:0] mem    [2048];
  logic [31:0] golden [2048];
  bit          m_valid [16];
  bit          m_dirty [16];
  logic [4:0]  m_tag   [16];
  int unsigned m_hits, m_misses;

  typedef struct {
    bit          is_load;
    logic [31:0] data;
    bit          exp_miss;
    int          exp_stall;
    string       nm;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit          we;
    logic [10:0] a;
    logic [31:0] wd;
  } beat_t;
  beat_t bq[$];

  int policy = 0;
  int ph = 0;

  always @(negedge clk) begin : responder
    bit rdy;
    ph++;
    rdy = 1'b0;
    if (mem_req === 1'b1) begin
      case (policy)
        0:       rdy = 1'b1;
        1:       rdy = (ph % 3 == 0);
        default: rdy = ($urandom_range(0, 2) == 0);
      endcase
    end
    mem_ready = rdy;
    mem_rdata = (rdy && !mem_we) ? mem[mem_addr] : 32'h0;
    if (rdy) begin
      bq.push_back('{we: mem_we, a: mem_addr, wd: mem_wdata});
      if (mem_we) mem[mem_addr] = mem_wdata;
    end
  end

  bit mon_en = 1'b1;
  int stall = 0;
  int last_stall = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en && rst_n && (re || we)) begin
      if (miss) stall++;
      else begin
        if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          if (e.is_load) chk({e.nm, "_rdata"}, rdata, e.data);
          chk({e.nm, "_missed"}, 32'(stall > 0), 32'(e.exp_miss));
          if (e.exp_stall >= 0) chk({e.nm, "_stall"}, stall, e.exp_stall);
        end
        last_stall = stall;
        stall = 0;
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 2048; i++) golden[i] = mem[i];
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_hits = 0;
    m_misses = 0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the request is serviced.
  task automatic issue(input logic [10:0] a, input bit w, input bit r,
                       input logic [31:0] d, input string nm);
    exp_t        e;
    int unsigned ix;
    logic [4:0]  tg;
    bit          h;
    ix = 32'(a[5:2]);
    tg = a[10:6];
    h  = m_valid[ix] && (m_tag[ix] == tg);
    e.exp_miss  = !h;
    e.exp_stall = -1;
    if (!h) begin
      m_misses++;
      if (policy == 0) e.exp_stall = (m_valid[ix] && m_dirty[ix]) ? 10 : 6;
      m_valid[ix] = 1'b1;
      m_tag[ix]   = tg;
      m_dirty[ix] = 1'b0;
    end else if (policy == 0) begin
      e.exp_stall = 0;
    end
    m_hits++;
    if (w) begin
      golden[a]   = d;
      m_dirty[ix] = 1'b1;
    end
    e.is_load = r && !w;
    e.data    = golden[a];
    e.nm      = nm;
    sb.push_back(e);
    addr = a; we = w; re = r; wdata = d;
    for (int c = 0; ; c++) begin
      @(negedge clk);
      if (!miss) break;
      if (c > 400) begin
        chk({nm, "_timeout"}, 32'd0, 32'd1);
        finish_sim();
      end
    end
    @(posedge clk);
    #1;
    we = 1'b0;
    re = 1'b0;
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [10:0] ra;
    int          op;
    rst_n = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 2048; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[16 + i] = 32'hA0A0_0000 | 32'(i);
    model_reset();

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hit_cnt", hit_cnt, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_miss", 32'(miss), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Cold read, then same-line hit.
    issue(11'h010, 1'b0, 1'b1, 32'h0, "t1_cold");
    chk("t1_hit_cnt", hit_cnt, 32'd1);
    chk("t1_miss_cnt", miss_cnt, 32'd1);
    bq.delete();
    issue(11'h011, 1'b0, 1'b1, 32'h0, "t2_hit");
    chk("t2_no_beats", 32'(bq.size()), 32'd0);

    // Dirty eviction.
    issue(11'h010, 1'b1, 1'b0, 32'hDEAD_BEEF, "t3_store");
    bq.delete();
    issue(11'h050, 1'b0, 1'b1, 32'h0, "t3_conflict");
    chk("t3_beats", 32'(bq.size()), 32'd8);
    for (int i = 0; i < 8 && i < bq.size(); i++) begin
      chk($sformatf("t3_beat%0d_we", i), 32'(bq[i].we), (i < 4) ? 32'd1 : 32'd0);
      chk($sformatf("t3_beat%0d_addr", i), 32'(bq[i].a),
          (i < 4) ? 32'h010 + 32'(i) : 32'h050 + 32'(i - 4));
    end
    if (bq.size() > 0) chk("t3_first_wdata", bq[0].wd, 32'hDEAD_BEEF);

    // Simultaneous we&re behaves as a store and dirties the line.
    issue(11'h050, 1'b1, 1'b1, 32'h5, "t6_st");
    issue(11'h050, 1'b0, 1'b1, 32'h0, "t6_ld");
    bq.delete();
    issue(11'h010, 1'b0, 1'b1, 32'h0, "t6_evict");
    if (bq.size() > 0) begin
      chk("t6_wb_we", 32'(bq[0].we), 32'd1);
      chk("t6_wb_addr", 32'(bq[0].a), 32'h050);
      chk("t6_wb_data", bq[0].wd, 32'h5);
    end else chk("t6_wb_present", 32'd0, 32'd1);

    // Wait states: ready every third cycle.
    policy = 1;
    bq.delete();
    issue(11'h030, 1'b0, 1'b1, 32'h0, "t4_ws");
    chk("t4_beats", 32'(bq.size()), 32'd4);
    for (int i = 0; i < 4 && i < bq.size(); i++)
      chk($sformatf("t4_beat%0d_addr", i), 32'(bq[i].a), 32'h030 + 32'(i));
    chk("t4_stall_ge12", 32'(last_stall >= 12), 32'd1);
    policy = 0;

    // Reset after two FILL beats.
    mon_en = 1'b0;
    bq.delete();
    addr = 11'h020; re = 1'b1;
    for (int c = 0; bq.size() < 2; c++) begin
      @(negedge clk);
      if (c > 20) begin
        chk("t5_beat_timeout", 32'd0, 32'd1);
        finish_sim();
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    re = 1'b0;
    @(negedge clk);
    chk("t5_mem_req", 32'(mem_req), 32'd0);
    chk("t5_hit_cnt", hit_cnt, 32'd0);
    chk("t5_miss_cnt", miss_cnt, 32'd0);
    chk("t5_miss", 32'(miss), 32'd0);
    rst_n = 1'b1;
    model_reset();
    stall = 0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    issue(11'h020, 1'b0, 1'b1, 32'h0, "t5_reread");
    chk("t5_miss_cnt_after", miss_cnt, 32'd1);

    // Randomised traffic over a few tags/indices to force conflicts and evictions.
    for (int n = 0; n < 300; n++) begin
      policy = $urandom_range(0, 2);
      ra = {5'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      op = $urandom_range(0, 2);
      issue(ra, op != 0, op != 1, $urandom, "rnd");
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    policy = 0;

    chk("final_hit_cnt", hit_cnt, m_hits);
    chk("final_miss_cnt", miss_cnt, m_misses);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    finish_sim();
  end

endmodule
